// File: rtl/ece385_7485_serial_seq.sv
// Nibble-serial magnitude compare through one external 7485-style comparator.
// LSB nibble first; the comparator's outputs are registered as the next cascade inputs.
module ece385_7485_serial_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    output logic                 busy,
    output logic                 done,
    output logic                 gt,
    output logic                 eq,
    output logic                 lt,
    output logic [3:0]           cmp_A,
    output logic [3:0]           cmp_B,
    output logic                 cmp_lt_in,
    output logic                 cmp_eq_in,
    output logic                 cmp_gt_in,
    input  logic                 cmp_gt_out,
    input  logic                 cmp_eq_out,
    input  logic                 cmp_lt_out
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [4*NIBBLES-1:0] a_reg;
    logic [4*NIBBLES-1:0] b_reg;
    logic [IW-1:0]        idx;
    logic [2:0]           casc;
    logic                 accept;
    logic                 last;

    // The DONE-exit edge may already accept the next request.
    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (state == RUN) && (idx == LAST);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        cmp_A     = 4'h0;
        cmp_B     = 4'h0;
        cmp_lt_in = 1'b0;
        cmp_eq_in = 1'b1;
        cmp_gt_in = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                busy      = 1'b1;
                cmp_A     = a_reg[{idx, 2'b00} +: 4];
                cmp_B     = b_reg[{idx, 2'b00} +: 4];
                cmp_lt_in = casc[2];
                cmp_eq_in = casc[1];
                cmp_gt_in = casc[0];
                if (idx == LAST) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = start ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_reg <= '0;
            b_reg <= '0;
            idx   <= '0;
            casc  <= 3'b010;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
        end else if (accept) begin
            a_reg <= A;
            b_reg <= B;
            idx   <= '0;
            casc  <= 3'b010;
        end else if (state == RUN) begin
            casc <= {cmp_lt_out, cmp_eq_out, cmp_gt_out};
            idx  <= idx + 1'b1;
            if (last) begin
                gt <= cmp_gt_out;
                eq <= cmp_eq_out;
                lt <= cmp_lt_out;
            end
        end
    end

endmodule

// File: tb/tb_ece385_7485_serial_seq.sv
// Bench for ece385_7485_serial_seq with a behavioural 7485 on the cmp_* ports.
// Expected results come from whole-operand arithmetic comparison.
module tb_ece385_7485_serial_seq;

    localparam int N = 4;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        busy, done, gt, eq, lt;
    logic [3:0]  cmp_A, cmp_B;
    logic        cmp_lt_in, cmp_eq_in, cmp_gt_in;
    logic        cmp_gt_out, cmp_eq_out, cmp_lt_out;

    int checks = 0;
    int errors = 0;

    ece385_7485_serial_seq #(.NIBBLES(N)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt),
        .cmp_A(cmp_A), .cmp_B(cmp_B),
        .cmp_lt_in(cmp_lt_in), .cmp_eq_in(cmp_eq_in), .cmp_gt_in(cmp_gt_in),
        .cmp_gt_out(cmp_gt_out), .cmp_eq_out(cmp_eq_out), .cmp_lt_out(cmp_lt_out)
    );

    always #5 Clk = ~Clk;

    // 7485 behaviour: magnitude decides, equal nibbles pass the cascade through
    always_comb begin
        cmp_gt_out = (cmp_A > cmp_B) || (cmp_A == cmp_B && cmp_gt_in && !cmp_eq_in);
        cmp_lt_out = (cmp_A < cmp_B) || (cmp_A == cmp_B && cmp_lt_in && !cmp_eq_in);
        cmp_eq_out = (cmp_A == cmp_B) && cmp_eq_in;
    end

    function automatic logic [31:0] res(input logic [31:0] a, input logic [31:0] b);
        return {29'd0, a < b, a == b, a > b};
    endfunction

    function automatic logic [31:0] low_res(input logic [31:0] a, input logic [31:0] b,
                                            input int k);
        logic [31:0] m;
        m = (32'd1 << (4 * k)) - 32'd1;
        return res(a & m, b & m);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] result();
        return {29'd0, lt, eq, gt};
    endfunction

    function automatic logic [31:0] casc_in();
        return {29'd0, cmp_lt_in, cmp_eq_in, cmp_gt_in};
    endfunction

    // Called #1 after an edge with the DUT idle.
    task automatic run_cmp(input logic [15:0] a, input logic [15:0] b, input string tag);
        logic [31:0] ea, eb;
        ea = {16'd0, a};
        eb = {16'd0, b};
        A = a;
        B = b;
        start = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        A = 16'($urandom);
        B = 16'($urandom);
        for (int k = 0; k < N; k++) begin
            chk({tag, "/busy"}, 32'(busy), 32'd1);
            chk({tag, "/done_early"}, 32'(done), 32'd0);
            chk({tag, "/cmp_A"}, 32'(cmp_A), (ea >> (4 * k)) & 32'hF);
            chk({tag, "/cmp_B"}, 32'(cmp_B), (eb >> (4 * k)) & 32'hF);
            chk({tag, "/cascade"}, casc_in(), low_res(ea, eb, k));
            @(posedge Clk);
            #1;
        end
        chk({tag, "/done"}, 32'(done), 32'd1);
        chk({tag, "/result"}, result(), res(ea, eb));
        @(posedge Clk);
        #1;
        chk({tag, "/done_fall"}, 32'(done), 32'd0);
        chk({tag, "/idle"}, 32'(busy), 32'd0);
        chk({tag, "/hold"}, result(), res(ea, eb));
    endtask

    initial begin
        logic [15:0] ra, rb;
        int sel;

        repeat (2) @(posedge Clk);
        #1;
        chk("rst/busy", 32'(busy), 32'd0);
        chk("rst/done", 32'(done), 32'd0);
        chk("rst/result", result(), 32'd0);
        chk("rst/cmp_A", 32'(cmp_A), 32'd0);
        chk("rst/cascade", casc_in(), 32'd2);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        run_cmp(16'h1234, 16'h1234, "eq1234");
        run_cmp(16'h8000, 16'h7FFF, "gt8000");
        run_cmp(16'h12F0, 16'h1301, "lt12F0");
        run_cmp(16'h00A5, 16'h00A3, "gt00A5");

        // start held through DONE: completion edge ignores it, DONE exit accepts it
        A = 16'd1;
        B = 16'd2;
        start = 1'b1;
        @(posedge Clk);
        #1;
        A = 16'd9;
        B = 16'd0;
        repeat (3) begin
            @(posedge Clk);
            #1;
            chk("hold/done_early", 32'(done), 32'd0);
        end
        @(posedge Clk);
        #1;
        chk("hold/done1", 32'(done), 32'd1);
        chk("hold/result1", result(), 32'd4);
        @(posedge Clk);
        #1;
        start = 1'b0;
        chk("hold/accept", 32'(busy), 32'd1);
        chk("hold/done_fall", 32'(done), 32'd0);
        chk("hold/cmp_A", 32'(cmp_A), 32'd9);
        repeat (3) begin
            @(posedge Clk);
            #1;
            chk("hold/done_early2", 32'(done), 32'd0);
        end
        @(posedge Clk);
        #1;
        chk("hold/done2", 32'(done), 32'd1);
        chk("hold/result2", result(), 32'd1);
        @(posedge Clk);
        #1;

        // reset mid-RUN at index 2
        A = 16'h0F0F;
        B = 16'h0F0E;
        start = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("abort/pre", 32'(busy), 32'd1);
        Reset_n = 1'b0;
        #1;
        chk("abort/busy", 32'(busy), 32'd0);
        chk("abort/done", 32'(done), 32'd0);
        chk("abort/result", result(), 32'd0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        repeat (6) begin
            @(posedge Clk);
            #1;
            chk("abort/no_done", 32'(done), 32'd0);
            chk("abort/no_busy", 32'(busy), 32'd0);
        end
        run_cmp(16'h0005, 16'h0005, "eq5");

        for (int i = 0; i < 16; i++) begin
            ra = 16'($urandom);
            sel = int'($urandom_range(0, 2));
            if (sel == 0) rb = ra;
            else if (sel == 1) rb = ra ^ (16'h1 << (4 * $urandom_range(0, 3)));
            else rb = 16'($urandom);
            run_cmp(ra, rb, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
